// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: one request at a time, fixed-latency response held until accepted.
// Optional MEM_ERR_EN adds rsp_err and flags addresses beyond the array instead of aliasing them.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUSY  | latency countdown; access performed when count reaches 1
// RESP  | rsp_valid high, response held until rsp_ready
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [`ADDRESS_WIDTH-1:2] req_addr,
  input  logic [`WORD_WIDTH-1:0]    req_wdata,
  input  logic [3:0]                req_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [`WORD_WIDTH-1:0]    rsp_rdata
`ifdef MEM_ERR_EN
  ,
  output logic                      rsp_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                state;
  logic [3:0]                cnt;
  logic                      hold_we;
  logic [`ADDRESS_WIDTH-1:2] hold_addr;
  logic [`WORD_WIDTH-1:0]    hold_wdata;
  logic [3:0]                hold_be;
  logic [DEPTH_LOG2-1:0]     idx;
  logic                      addr_err;
  logic                      do_access;

  logic [`WORD_WIDTH-1:0] mem [2**DEPTH_LOG2];

  assign idx       = hold_addr[DEPTH_LOG2+1:2];
  assign do_access = (state == BUSY) && (cnt == 4'd1);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

`ifdef MEM_ERR_EN
  logic err_q;
  assign addr_err = |hold_addr[`ADDRESS_WIDTH-1:DEPTH_LOG2+2];
  assign rsp_err  = err_q;
`else
  // Upper address bits are deliberately dropped so out-of-range addresses alias.
  logic unused_addr_hi;
  assign addr_err       = 1'b0;
  assign unused_addr_hi = ^hold_addr[`ADDRESS_WIDTH-1:DEPTH_LOG2+2];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= 4'd0;
      rsp_rdata  <= '0;
`ifdef MEM_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            hold_we    <= req_we;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
            hold_be    <= req_be;
            cnt        <= 4'(LATENCY);
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            if (hold_we || addr_err) rsp_rdata <= '0;
            else                     rsp_rdata <= mem[idx];
`ifdef MEM_ERR_EN
            err_q <= addr_err;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
`ifdef MEM_ERR_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a reset before the access cycle leaves it untouched.
  always_ff @(posedge clk) begin
    if (do_access && hold_we && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_be[b]) mem[idx][8*b +: 8] <= hold_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: scoreboarded directed steps on a LATENCY=2
// instance plus a LATENCY=1 instance for back-to-back throughput.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_data_mem_responder;

  localparam int DL = 10;
  localparam int AW = `ADDRESS_WIDTH - 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                      a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic [`ADDRESS_WIDTH-1:2] a_req_addr;
  logic [`WORD_WIDTH-1:0]    a_req_wdata, a_rsp_rdata;
  logic [3:0]                a_req_be;
  logic                      a_rsp_err;

  logic                      b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [`ADDRESS_WIDTH-1:2] b_req_addr;
  logic [`WORD_WIDTH-1:0]    b_req_wdata, b_rsp_rdata;
  logic [3:0]                b_req_be;
  logic                      b_rsp_err;

  data_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata)
`ifdef MEM_ERR_EN
    , .rsp_err(a_rsp_err)
`endif
  );

  data_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata)
`ifdef MEM_ERR_EN
    , .rsp_err(b_rsp_err)
`endif
  );

`ifndef MEM_ERR_EN
  assign a_rsp_err = 1'b0;
  assign b_rsp_err = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  exp_t sbq[$];
  exp_t sbq_b[$];
  logic [31:0] model_mem [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_is_err(input int addr);
`ifdef MEM_ERR_EN
    return (addr >> DL) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_push(input logic we, input int addr, input logic [31:0] wdata,
                            input logic [3:0] be);
    exp_t e;
    int   i;
    i = addr % (1 << DL);
    e.err  = addr_is_err(addr);
    e.data = 32'h0;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[i][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.data = model_mem[i];
      end
    end
    sbq.push_back(e);
  endtask

  // Ends on the falling edge just after the acceptance edge.
  task automatic a_send(input logic we, input int addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit push);
    int n;
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = AW'(addr);
    a_req_wdata = wdata;
    a_req_be    = be;
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_req_ready", a_req_ready, 1);
    if (push) model_push(we, addr, wdata, be);
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic a_wait_rsp(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!a_rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_sb_pending"}, sbq.size() != 0, 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_rdata"}, a_rsp_rdata, e.data);
`ifdef MEM_ERR_EN
      chk({tag, "_err"}, a_rsp_err, e.err);
`endif
    end
  endtask

  task automatic a_ack(input string tag);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, a_rsp_valid, 0);
`ifdef MEM_ERR_EN
    chk({tag, "_err_clear"}, a_rsp_err, 0);
`endif
  endtask

  task automatic a_txn(input string tag, input logic we, input int addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    a_send(we, addr, wdata, be, 1'b1);
    a_wait_rsp(tag);
    a_ack(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t eb;
    int   n;
    rst = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", a_req_ready, 1);
    chk("reset_rsp_valid", a_rsp_valid, 0);
    chk("reset_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("reset_rsp_err", a_rsp_err, 0);
    rst = 1'b1;

    a_txn("wr_full", 1'b1, 5, 32'hDEADBEEF, 4'b1111);
    a_txn("rd_full", 1'b0, 5, 32'h0, 4'b0000);
    a_txn("wr_byte0", 1'b1, 5, 32'h000000AA, 4'b0001);
    a_txn("rd_byte0", 1'b0, 5, 32'h0, 4'b0000);
    a_txn("wr_be0", 1'b1, 5, 32'hFFFFFFFF, 4'b0000);
    a_txn("rd_be0", 1'b0, 5, 32'h0, 4'b0000);
    a_txn("wr_7", 1'b1, 7, 32'h11223344, 4'b1111);

    // Response stall with a competing request present.
    a_send(1'b0, 5, 32'h0, 4'b0000, 1'b1);
    a_wait_rsp("stall_rd5");
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = AW'(7); a_req_be = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", a_rsp_valid, 1);
      chk("stall_rsp_rdata", a_rsp_rdata, model_mem[5]);
      chk("stall_req_ready", a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("stall_release_valid", a_rsp_valid, 0);
    chk("stall_release_ready", a_req_ready, 1);
    model_push(1'b0, 7, 32'h0, 4'b0000);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_wait_rsp("second_rd7");
    a_ack("second_rd7");

    // Reset while a write sits in BUSY with the counter at 2.
    a_send(1'b1, 5, 32'h12345678, 4'b1111, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", a_req_ready, 1);
    chk("midrst_rsp_valid", a_rsp_valid, 0);
    chk("midrst_rsp_rdata", a_rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    a_txn("post_rst_rd5", 1'b0, 5, 32'h0, 4'b0000);
    chk("post_rst_value", model_mem[5], 32'hDEADBEAA);

    a_txn("rd_alias_1029", 1'b0, 5 + (1 << DL), 32'h0, 4'b0000);
`ifdef MEM_ERR_EN
    a_txn("wr_err_1029", 1'b1, 5 + (1 << DL), 32'h0, 4'b1111);
    a_txn("rd5_after_err", 1'b0, 5, 32'h0, 4'b0000);
`endif

    // LATENCY=1 instance: seed a word, then back-to-back reads.
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = AW'(3);
    b_req_wdata = 32'hCAFEF00D; b_req_be = 4'b1111;
    @(negedge clk);
    b_req_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_wr_latency", n, 1);
    n = 0;
    while (!b_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_again", b_req_ready, 1);

    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = AW'(3); b_req_be = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      chk("b_req_ready_pattern", b_req_ready, (i % 3) == 0);
      chk("b_rsp_valid_pattern", b_rsp_valid, (i % 3) == 2);
      if (b_req_ready) begin
        eb.data = 32'hCAFEF00D;
        eb.err  = 1'b0;
        sbq_b.push_back(eb);
      end
      if (b_rsp_valid) begin
        chk("b_sb_pending", sbq_b.size() != 0, 1);
        if (sbq_b.size() != 0) begin
          eb = sbq_b.pop_front();
          chk("b_rdata", b_rsp_rdata, eb.data);
        end
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
